// File: rtl/calc_pkg.sv
// Shared calculator definitions used by the tone detector and the buzzer driver.
// Contents:
//   state_t       - tone detector FSM states (IDLE, ARM, LOCK)
//   NOTE_LA_HALF  - half-period of the "La" note in USER_CLK cycles; both ends use
//                   it so the driver and the detector agree on the note
//   TOL_DEFAULT   - default accepted half-period deviation in cycles
//   sat_inc8      - 8-bit increment that sticks at 255
package calc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        LOCK = 2'd2
    } state_t;

    localparam int NOTE_LA_HALF = 213637;
    localparam int TOL_DEFAULT  = 2048;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == 8'hFF) begin
            return 8'hFF;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser plus a history flop for an asynchronous input line.
// edge_det is high for one clock whenever the synchronised level changes
// (rising or falling), two cycles after the input transition is first sampled.
// Ports:
//   clk      - sampling clock
//   rst_n    - asynchronous active-low reset (all flops to 0)
//   din      - asynchronous input
//   edge_det - one-cycle pulse on either edge of the synchronised input
module edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic edge_det
);

    logic meta_r;
    logic sync_r;
    logic hist_r;

    // Synchroniser chain followed by the history flop used for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b0;
            sync_r <= 1'b0;
            hist_r <= 1'b0;
        end else begin
            meta_r <= din;
            sync_r <= meta_r;
            hist_r <= sync_r;
        end
    end

    // Both flops are clocked together, so the XOR is a clean one-cycle pulse
    assign edge_det = sync_r ^ hist_r;

endmodule

// File: rtl/tone_detect.sv
// Tone burst detector: measures half-periods of a square-wave line, locks once
// MIN_TOGGLES consecutive half-periods fall inside NOTE_HALF +/- TOL, and reports
// the toggle count of each locked burst when the line goes quiet for TIMEOUT cycles.
// Ports:
//   USER_CLK      - system clock
//   RESET_N       - asynchronous active-low reset
//   TONE_IN       - asynchronous square-wave input
//   tone_present  - high while a valid burst is locked
//   burst_done    - one-cycle pulse when a locked burst ends
//   burst_toggles - toggle count of the last completed burst (saturates at 255)
//   last_period   - most recent measured half-period
//   bad_edge      - one-cycle pulse on an out-of-window edge while arming or locked
module tone_detect
    import calc_pkg::*;
#(
    parameter int NOTE_HALF   = NOTE_LA_HALF,
    parameter int TOL         = TOL_DEFAULT,
    parameter int MIN_TOGGLES = 8,
    parameter int TIMEOUT     = 427274,
    parameter int CW          = 19
) (
    input  logic          USER_CLK,
    input  logic          RESET_N,
    input  logic          TONE_IN,
    output logic          tone_present,
    output logic          burst_done,
    output logic [7:0]    burst_toggles,
    output logic [CW-1:0] last_period,
    output logic          bad_edge
);

    // Window limits carry one extra bit so NOTE_HALF+TOL never wraps
    localparam logic [CW:0]   WIN_LO   = (CW+1)'(NOTE_HALF - TOL);
    localparam logic [CW:0]   WIN_HI   = (CW+1)'(NOTE_HALF + TOL);
    localparam logic [CW-1:0] TMO      = CW'(TIMEOUT);
    localparam logic [7:0]    MIN_RUN  = 8'(MIN_TOGGLES);

    logic          edge_s;
    logic [CW-1:0] per_ctr_r;
    logic [CW:0]   period_s;
    logic          in_win_s;
    logic          timeout_s;
    logic [7:0]    run_inc_s;

    state_t        state_r,         state_nxt_s;
    logic [7:0]    run_cnt_r,       run_cnt_nxt_s;
    logic [7:0]    tog_cnt_r,       tog_cnt_nxt_s;
    logic          tone_present_r,  tone_present_nxt_s;
    logic          burst_done_r,    burst_done_nxt_s;
    logic [7:0]    burst_toggles_r, burst_toggles_nxt_s;
    logic [CW-1:0] last_period_r,   last_period_nxt_s;
    logic          bad_edge_r,      bad_edge_nxt_s;

    edge_sync u_edge_sync (
        .clk      (USER_CLK),
        .rst_n    (RESET_N),
        .din      (TONE_IN),
        .edge_det (edge_s)
    );

    // Measured half-period counts the edge cycle itself, hence the +1
    assign period_s  = {1'b0, per_ctr_r} + {{CW{1'b0}}, 1'b1};
    assign in_win_s  = (period_s >= WIN_LO) && (period_s <= WIN_HI);
    // An edge landing on the saturation cycle wins over the timeout
    assign timeout_s = (per_ctr_r == TMO) && !edge_s;
    assign run_inc_s = run_cnt_r + 8'd1;

    // Half-period counter: restarts on every edge, sticks at TIMEOUT
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            per_ctr_r <= '0;
        end else if (edge_s) begin
            per_ctr_r <= '0;
        end else if (per_ctr_r != TMO) begin
            per_ctr_r <= per_ctr_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            per_ctr_r <= per_ctr_r;
        end
    end

    // Next-state and next-output decisions for the arming/lock FSM
    always_comb begin
        state_nxt_s         = state_r;
        run_cnt_nxt_s       = run_cnt_r;
        tog_cnt_nxt_s       = tog_cnt_r;
        tone_present_nxt_s  = tone_present_r;
        burst_done_nxt_s    = 1'b0;
        burst_toggles_nxt_s = burst_toggles_r;
        last_period_nxt_s   = last_period_r;
        bad_edge_nxt_s      = 1'b0;

        case (state_r)
            IDLE: begin
                // The first edge has no meaningful preceding period
                if (edge_s) begin
                    state_nxt_s   = ARM;
                    tog_cnt_nxt_s = 8'd1;
                    run_cnt_nxt_s = 8'd0;
                end else begin
                    state_nxt_s   = IDLE;
                end
            end
            ARM: begin
                if (edge_s) begin
                    last_period_nxt_s = period_s[CW-1:0];
                    if (in_win_s) begin
                        run_cnt_nxt_s = run_inc_s;
                        tog_cnt_nxt_s = sat_inc8(tog_cnt_r);
                        if (run_inc_s == MIN_RUN) begin
                            state_nxt_s        = LOCK;
                            tone_present_nxt_s = 1'b1;
                        end else begin
                            state_nxt_s = ARM;
                        end
                    end else begin
                        // Restart arming, counting this edge as the first toggle
                        bad_edge_nxt_s = 1'b1;
                        run_cnt_nxt_s  = 8'd0;
                        tog_cnt_nxt_s  = 8'd1;
                    end
                end else if (timeout_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ARM;
                end
            end
            LOCK: begin
                if (edge_s) begin
                    last_period_nxt_s = period_s[CW-1:0];
                    tog_cnt_nxt_s     = sat_inc8(tog_cnt_r);
                    bad_edge_nxt_s    = !in_win_s;
                end else if (timeout_s) begin
                    burst_done_nxt_s    = 1'b1;
                    burst_toggles_nxt_s = tog_cnt_r;
                    tone_present_nxt_s  = 1'b0;
                    state_nxt_s         = IDLE;
                end else begin
                    state_nxt_s = LOCK;
                end
            end
            default: begin
                state_nxt_s        = IDLE;
                tone_present_nxt_s = 1'b0;
            end
        endcase
    end

    // FSM state, counters and registered outputs
    always_ff @(posedge USER_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_r         <= IDLE;
            run_cnt_r       <= 8'd0;
            tog_cnt_r       <= 8'd0;
            tone_present_r  <= 1'b0;
            burst_done_r    <= 1'b0;
            burst_toggles_r <= 8'd0;
            last_period_r   <= '0;
            bad_edge_r      <= 1'b0;
        end else begin
            state_r         <= state_nxt_s;
            run_cnt_r       <= run_cnt_nxt_s;
            tog_cnt_r       <= tog_cnt_nxt_s;
            tone_present_r  <= tone_present_nxt_s;
            burst_done_r    <= burst_done_nxt_s;
            burst_toggles_r <= burst_toggles_nxt_s;
            last_period_r   <= last_period_nxt_s;
            bad_edge_r      <= bad_edge_nxt_s;
        end
    end

    assign tone_present  = tone_present_r;
    assign burst_done    = burst_done_r;
    assign burst_toggles = burst_toggles_r;
    assign last_period   = last_period_r;
    assign bad_edge      = bad_edge_r;

endmodule

// File: tb/tb_tone_detect.sv
// Self-checking bench for tone_detect with a small note (half-period 100 cycles).
// Stimulus is a sequence of toggle gaps; the reference model works on detected edge
// timestamps (edge = toggle + 3 clocks) and derives the expected outputs from
// the gaps between edges, checked every clock.
module tb_tone_detect;

    localparam int NH  = 100;
    localparam int TL  = 4;
    localparam int MT  = 4;
    localparam int TO  = 250;
    localparam int CWB = 9;

    localparam int M_IDLE = 0;
    localparam int M_ARM  = 1;
    localparam int M_LOCK = 2;

    logic           clk;
    logic           rst_n;
    logic           tone_in;
    logic           tone_present;
    logic           burst_done;
    logic [7:0]     burst_toggles;
    logic [CWB-1:0] last_period;
    logic           bad_edge;

    tone_detect #(
        .NOTE_HALF   (NH),
        .TOL         (TL),
        .MIN_TOGGLES (MT),
        .TIMEOUT     (TO),
        .CW          (CWB)
    ) dut (
        .USER_CLK      (clk),
        .RESET_N       (rst_n),
        .TONE_IN       (tone_in),
        .tone_present  (tone_present),
        .burst_done    (burst_done),
        .burst_toggles (burst_toggles),
        .last_period   (last_period),
        .bad_edge      (bad_edge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // reference model state
    int edge_q[$];
    int gq[$];
    int last_edge = 0;
    int mode      = M_IDLE;
    int run       = 0;
    int tog       = 0;
    bit in_reset  = 1'b1;
    int e_present = 0;
    int e_done    = 0;
    int e_bt      = 0;
    int e_lp      = 0;
    int e_bad     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d at cycle %0d", tag, obs, expv, cyc);
        end
    endtask

    task automatic check_all();
        vectors++;
        chk("tone_present",  {31'd0, tone_present},  32'(e_present));
        chk("burst_done",    {31'd0, burst_done},    32'(e_done));
        chk("burst_toggles", {24'd0, burst_toggles}, 32'(e_bt));
        chk("last_period",   {23'd0, last_period},   32'(e_lp));
        chk("bad_edge",      {31'd0, bad_edge},      32'(e_bad));
    endtask

    task automatic model_clear();
        mode = M_IDLE; run = 0; tog = 0;
        e_present = 0; e_done = 0; e_bt = 0; e_lp = 0; e_bad = 0;
        edge_q.delete();
    endtask

    // one clock: advance the model at the edge, compare 1 time unit later
    task automatic tick();
        bit ev;
        int gap;
        int p;
        bit win;
        @(posedge clk);
        cyc++;
        e_done = 0;
        e_bad  = 0;
        if (!in_reset) begin
            ev = (edge_q.size() > 0) && (edge_q[0] == cyc);
            if (ev) void'(edge_q.pop_front());
            if (ev) begin
                gap = cyc - last_edge;
                p   = (gap > TO) ? TO + 1 : gap;
                win = (p >= NH - TL) && (p <= NH + TL);
                if (mode == M_IDLE) begin
                    mode = M_ARM; tog = 1; run = 0;
                end else if (mode == M_ARM) begin
                    e_lp = p;
                    if (win) begin
                        run++; tog++;
                        if (run == MT) begin
                            mode = M_LOCK; e_present = 1;
                        end
                    end else begin
                        e_bad = 1; run = 0; tog = 1;
                    end
                end else begin
                    e_lp = p;
                    tog  = (tog < 255) ? tog + 1 : 255;
                    e_bad = win ? 0 : 1;
                end
                last_edge = cyc;
            end else if (mode != M_IDLE && (cyc - last_edge - 1) == TO) begin
                if (mode == M_LOCK) begin
                    e_done = 1; e_bt = tog; e_present = 0;
                end
                mode = M_IDLE;
            end
        end
        #1;
        check_all();
    endtask

    task automatic toggle_then(input int g);
        tone_in = ~tone_in;
        edge_q.push_back(cyc + 3);
        repeat (g) tick();
    endtask

    task automatic run_gaps();
        foreach (gq[i]) toggle_then(gq[i]);
        gq.delete();
    endtask

    task automatic burst(input int n, input int gap);
        for (int i = 0; i < n; i++) gq.push_back((i == n - 1) ? 270 : gap);
        run_gaps();
    endtask

    task automatic release_reset();
        tone_in   = 1'b0;
        rst_n     = 1'b1;
        in_reset  = 1'b0;
        last_edge = cyc;
    endtask

    initial begin
        rst_n   = 1'b0;
        tone_in = 1'b0;
        model_clear();
        repeat (3) tick();
        release_reset();
        repeat (5) tick();

        // 1: clean 60-toggle burst
        burst(60, 100);

        // 2: every half-period out of window, never locks
        burst(20, 110);

        // 3: one short half-period inside a locked burst
        for (int i = 0; i < 30; i++) gq.push_back((i == 29) ? 270 : ((i == 14) ? 90 : 100));
        run_gaps();

        // 4: window limits accepted, one-below-limit restarts arming, then relock
        gq = '{96, 104, 96, 95, 104, 96, 104, 96, 270};
        run_gaps();
        gq = '{104, 105, 100, 270};
        run_gaps();

        // 5: asynchronous reset during a locked burst
        for (int i = 0; i < 20; i++) toggle_then(100);
        repeat (10) tick();
        rst_n    = 1'b0;
        in_reset = 1'b1;
        model_clear();
        #1;
        check_all();
        repeat (3) tick();
        release_reset();
        repeat (5) tick();
        burst(60, 100);

        // 6: saturation and an edge exactly at the timeout count
        for (int i = 0; i < 301; i++) gq.push_back((i == 300) ? 270 : ((i == 299) ? 251 : 100));
        run_gaps();

        // randomized bursts with mostly in-window jitter
        for (int b = 0; b < 4; b++) begin
            int n;
            n = int'($urandom_range(10, 40));
            for (int i = 0; i < n; i++) begin
                if (i == n - 1) gq.push_back(270);
                else if ($urandom_range(0, 99) < 85) gq.push_back(int'($urandom_range(96, 104)));
                else gq.push_back(int'($urandom_range(80, 120)));
            end
            run_gaps();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
